// File: rtl/dp_pkg.sv
// dp_pkg: control encodings shared by the multicycle datapath and its controller.
package dp_pkg;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_src_t;
  typedef enum logic [1:0] {SRCA_PC, SRCA_OLDPC, SRCA_A, SRCA_ZERO} src_a_t;
  typedef enum logic [1:0] {SRCB_B, SRCB_IMM, SRCB_FOUR, SRCB_ZERO} src_b_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL} alu_op_t;
  typedef enum logic [1:0] {RES_ALUOUT, RES_DATA, RES_ALU, RES_IMM} result_src_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/register_file_p.sv
// register_file_p: 2R1W register file, x0 hardwired to zero, unused upper address bits ignored.
module register_file_p #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      a1,
  input  logic [4:0]      a2,
  input  logic [4:0]      a3,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  localparam int AW = $clog2(NREGS);
  logic [XLEN-1:0] regs [NREGS];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else if (we && a3[AW-1:0] != '0) regs[a3[AW-1:0]] <= wd;
  assign rd1 = a1[AW-1:0] == '0 ? '0 : regs[a1[AW-1:0]];
  assign rd2 = a2[AW-1:0] == '0 ? '0 : regs[a2[AW-1:0]];
endmodule

// File: rtl/datapath_multicycle.sv
// datapath_multicycle: multicycle RV32 datapath with a unified memory port; a memory stall freezes all state.
import dp_pkg::*;
module datapath_multicycle #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCWrite,
  input  logic            AdrSrc,
  input  logic            IRWrite,
  input  logic            MemAccess,
  input  logic            mem_ready,
  input  logic            RegWrite,
  input  logic [2:0]      ImmSrc,
  input  logic [1:0]      ALUSrcA,
  input  logic [1:0]      ALUSrcB,
  input  logic [2:0]      ALUControl,
  input  logic [1:0]      ResultSrc,
  input  logic [XLEN-1:0] ReadData,
  output logic [XLEN-1:0] Adr,
  output logic [XLEN-1:0] WriteData,
  output logic [31:0]     Instr,
  output logic            Zero,
  output logic            Stall
);
  localparam int SW = $clog2(XLEN);
  logic [XLEN-1:0] pc, old_pc, data, a, b, alu_out, rd1, rd2;
  logic [XLEN-1:0] imm_ext, src_a, src_b, alu_result, result;
  logic [31:0] ir;
  logic stall;
  assign stall = MemAccess & ~mem_ready;
  register_file_p #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk(clk), .rst(rst), .we(RegWrite & ~stall),
    .a1(ir[19:15]), .a2(ir[24:20]), .a3(ir[11:7]),
    .wd(result), .rd1(rd1), .rd2(rd2)
  );
  always_comb begin
    case (imm_src_t'(ImmSrc))
      IMM_I:   imm_ext = XLEN'($signed(ir[31:20]));
      IMM_S:   imm_ext = XLEN'($signed({ir[31:25], ir[11:7]}));
      IMM_B:   imm_ext = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
      IMM_J:   imm_ext = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
      IMM_U:   imm_ext = XLEN'($signed({ir[31:12], 12'b0}));
      default: imm_ext = '0;
    endcase
  end
  always_comb begin
    src_a = ALUSrcA == SRCA_PC ? pc : ALUSrcA == SRCA_OLDPC ? old_pc : ALUSrcA == SRCA_A ? a : '0;
    src_b = ALUSrcB == SRCB_B ? b : ALUSrcB == SRCB_IMM ? imm_ext : ALUSrcB == SRCB_FOUR ? XLEN'(4) : '0;
    result = ResultSrc == RES_ALUOUT ? alu_out : ResultSrc == RES_DATA ? data :
             ResultSrc == RES_ALU ? alu_result : imm_ext;
  end
  always_comb begin
    case (alu_op_t'(ALUControl))
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_XOR: alu_result = src_a ^ src_b;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLL: alu_result = src_a << src_b[SW-1:0];
      default: alu_result = src_a >> src_b[SW-1:0];
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_PC;
      old_pc <= RESET_PC;
      ir <= NOP_INSTR;
      data <= '0;
      a <= '0;
      b <= '0;
      alu_out <= '0;
    end else if (!stall) begin
      a <= rd1;
      b <= rd2;
      alu_out <= alu_result;
      data <= ReadData;
      if (PCWrite) pc <= result;
      if (IRWrite) begin
        ir <= ReadData[31:0];
        old_pc <= pc;
      end
    end
  assign Adr = AdrSrc ? result : pc;
  assign WriteData = b;
  assign Instr = ir;
  assign Zero = alu_result == '0;
  assign Stall = stall;
endmodule
